// File: rtl/hba_pkg.sv
// Shared definitions for the HBA peripheral bus: default widths, address-width
// derivation and the arbiter state encoding.
package hba_pkg;

  localparam int HBA_DBUS_WIDTH        = 8;
  localparam int HBA_PERIPH_ADDR_WIDTH = 4;
  localparam int HBA_REG_ADDR_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } hba_state_e;

  function automatic int hba_addr_w(input int periph_w, input int reg_w);
    return periph_w + reg_w;
  endfunction

  function automatic int hba_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hba_rr_picker.sv
// Combinational round-robin select: first requester found searching upward
// from rr_last+1, wrapping modulo N.
module hba_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output gets a default before the search loop so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDX_W'((int'(rr_last) + off) % N);
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/hba_master_arbiter.sv
// Round-robin arbiter sharing the HBA peripheral bus between several masters;
// one registered transfer per grant, with an ack watchdog.
module hba_master_arbiter
  import hba_pkg::*;
#(
  parameter int  NUM_MASTERS       = 2,
  parameter int  DBUS_WIDTH        = HBA_DBUS_WIDTH,
  parameter int  PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
  parameter int  REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
  parameter int  TIMEOUT_CYCLES    = 255,
  localparam int ADDR_W            = hba_addr_w(PERIPH_ADDR_WIDTH, REG_ADDR_WIDTH)
) (
  input  logic                              clk_100mhz,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            mst_req,
  input  logic [NUM_MASTERS-1:0]            mst_rnw,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     mst_addr,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] mst_wdata,
  output logic [NUM_MASTERS-1:0]            mst_grant,
  output logic [NUM_MASTERS-1:0]            mst_done,
  output logic [DBUS_WIDTH-1:0]             mst_rdata,
  output logic                              mst_err,
  output logic                              hba_xfer,
  output logic                              hba_rnw,
  output logic [ADDR_W-1:0]                 hba_addr,
  output logic [DBUS_WIDTH-1:0]             hba_wdata,
  input  logic                              hba_xferack,
  input  logic [DBUS_WIDTH-1:0]             hba_rdata
);

  localparam int         IDX_W    = hba_idx_w(NUM_MASTERS);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  hba_state_e           state;
  logic [IDX_W-1:0]     rr_last;
  logic [7:0]           cnt;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  hba_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req      (mst_req),
    .rr_last  (rr_last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mst_grant <= '0;
      mst_done  <= '0;
      mst_rdata <= '0;
      mst_err   <= 1'b0;
      hba_xfer  <= 1'b0;
      hba_rnw   <= 1'b0;
      hba_addr  <= '0;
      hba_wdata <= '0;
      rr_last   <= IDX_W'(NUM_MASTERS - 1);
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            mst_grant <= pick;
            hba_rnw   <= mst_rnw[pick_idx];
            hba_addr  <= mst_addr[pick_idx*ADDR_W +: ADDR_W];
            hba_wdata <= mst_wdata[pick_idx*DBUS_WIDTH +: DBUS_WIDTH];
            hba_xfer  <= 1'b1;
            rr_last   <= pick_idx;
            cnt       <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          // An ack arriving in the expiry cycle still counts as success.
          if (hba_xferack || cnt == TMO_LAST) begin
            mst_done  <= mst_grant;
            mst_err   <= !hba_xferack;
            mst_rdata <= (hba_xferack && hba_rnw) ? hba_rdata : '0;
            hba_xfer  <= 1'b0;
            mst_grant <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          mst_done  <= '0;
          mst_err   <= 1'b0;
          mst_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
